// File: rtl/leaf_arb_pkg.sv
// leaf_out_arbiter shared types and constants.
// Holds the FSM state enum, requester limit and stat width.
package leaf_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int ARB_MAX_REQ = 16;
  localparam int STAT_BITS   = 32;

  function automatic int unsigned wrap_inc(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 32'd1 == n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// Requester streams and shared output port of leaf_out_arbiter.
// slave = arbiter side, master = operators plus leaf_interface side.
interface leaf_out_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32
);

  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_dout;
  logic [NUM_REQ-1:0]              req_vld;
  logic [NUM_REQ-1:0]              req_ack;
  logic [PAYLOAD_BITS-1:0]         out_din;
  logic                            out_vld;
  logic                            out_ack;

  modport slave (
    input  req_dout,
    input  req_vld,
    input  out_ack,
    output req_ack,
    output out_din,
    output out_vld
  );

  modport master (
    output req_dout,
    output req_vld,
    output out_ack,
    input  req_ack,
    input  out_din,
    input  out_vld
  );

endinterface

// File: rtl/leaf_out_arbiter_rr_picker.sv
// Rotate-priority encoder: first valid requester at or above
// i_rr_ptr, wrapping modulo NUM_REQ.
module leaf_rr_picker
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_vld,
  input  logic [IW-1:0]      i_rr_ptr,
  output logic               o_found,
  output logic [IW-1:0]      o_idx
);

  int w_j;

  // Scan from the far end so the nearest hit wins last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = (int'(i_rr_ptr) + k) % NUM_REQ;
      if (i_req_vld[w_j]) begin
        o_found = 1'b1;
        o_idx   = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin burst arbiter onto one registered output port.
// Define LEAF_ARB_STATS_EN to add per-requester transfer counters.
module leaf_out_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int MAX_BURST    = 8
) (
  input  logic                         clk_user,
  input  logic                         reset_n,
  leaf_out_arbiter_if.slave            bus,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx
`ifdef LEAF_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_BITS-1:0] stat_count
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t              r_state;
  logic [IW-1:0]           r_rr_ptr;
  logic [IW-1:0]           r_grant;
  logic [BW-1:0]           r_burst_cnt;
  logic [PAYLOAD_BITS-1:0] r_out_din;
  logic                    r_out_vld;

  logic                    w_slot_free;
  logic                    w_found;
  logic                    w_xfer;
  logic                    w_burst_end;
  logic [IW-1:0]           w_pick;
  logic [IW-1:0]           w_sel;
  logic [IW-1:0]           w_rr_nxt;
  logic [NUM_REQ-1:0]      w_ack;

  leaf_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req_vld (bus.req_vld),
    .i_rr_ptr  (r_rr_ptr),
    .o_found   (w_found),
    .o_idx     (w_pick)
  );

  always_comb begin
    w_slot_free = !r_out_vld || bus.out_ack;
    w_sel       = (r_state == ARB) ? w_pick : r_grant;
    w_rr_nxt    = IW'(wrap_inc(32'(w_sel), NUM_REQ));
    w_burst_end = (r_burst_cnt == BW'(MAX_BURST - 1));
    w_xfer      = reset_n && w_slot_free &&
                  ((r_state == ARB) ? w_found
                                    : bus.req_vld[r_grant]);
    w_ack       = '0;
    if (w_xfer) w_ack[w_sel] = 1'b1;
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ARB;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_burst_cnt <= '0;
      r_out_din   <= '0;
      r_out_vld   <= 1'b0;
    end else begin
      // Accept and drain may share an edge: reload keeps vld high.
      if (w_xfer) begin
        r_out_din <= bus.req_dout[w_sel*PAYLOAD_BITS +: PAYLOAD_BITS];
        r_out_vld <= 1'b1;
      end else if (bus.out_ack) begin
        r_out_vld <= 1'b0;
      end
      case (r_state)
        ARB: begin
          if (w_xfer) begin
            r_grant     <= w_pick;
            r_burst_cnt <= BW'(1);
            if (MAX_BURST == 1) r_rr_ptr <= w_rr_nxt;
            else                r_state  <= LOCK;
          end
        end
        LOCK: begin
          if (!bus.req_vld[r_grant]) begin
            r_state  <= ARB;
            r_rr_ptr <= w_rr_nxt;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (w_burst_end) begin
              r_state  <= ARB;
              r_rr_ptr <= w_rr_nxt;
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign bus.req_ack = w_ack;
  assign bus.out_din = r_out_din;
  assign bus.out_vld = r_out_vld;
  assign grant_idx   = r_grant;

`ifdef LEAF_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [STAT_BITS-1:0] r_cnt;
    always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n)      r_cnt <= '0;
      else if (w_ack[g]) r_cnt <= r_cnt + 1'b1;
    end
    assign stat_count[g*STAT_BITS +: STAT_BITS] = r_cnt;
  end
`endif

endmodule
